// File: rtl/uart_fifo_link.sv
// rtl/uart_fifo_link.sv - parametrised full-duplex UART with RX and TX FIFOs
module uart_fifo_link_fifo #(
  parameter int W                = 8,
  parameter int DEPTH            = 16,
  parameter int PUSH_ON_FULL_POP = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [W-1:0]              wdata,
  input  logic                      pop,
  output logic [W-1:0]              rdata,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic         do_push, do_pop, full_slot_free;

  // A full FIFO may still accept a push when the same cycle frees a slot
  always_comb begin
    do_pop         = pop & ~empty;
    full_slot_free = (PUSH_ON_FULL_POP != 0) ? do_pop : 1'b0;
    do_push        = push & (~full | full_slot_free);
    wr_ptr_d       = wr_ptr + {{AW{1'b0}}, do_push};
    rd_ptr_d       = rd_ptr + {{AW{1'b0}}, do_pop};
  end

  // Pointers and flags; flags are registered from the next pointer values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      empty  <= (wr_ptr_d == rd_ptr_d);
      full   <= (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
      count  <= wr_ptr_d - rd_ptr_d;
    end
  end

  // Storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

module uart_fifo_link #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic                          tx,
  input  logic                          rx_rd_en,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  input  logic                          tx_wr_en,
  input  logic [DATA_W-1:0]             tx_data,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic                          tx_busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);
  localparam int   CNT_W = $clog2(CLKS_PER_BIT);
  localparam int   BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic PAR_ON  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;

  // ---------------------------------------------------------------- TX path
  logic [DATA_W-1:0] tx_head;
  logic              tx_pop;

  uart_fifo_link_fifo #(
    .W                (DATA_W),
    .DEPTH            (FIFO_DEPTH),
    .PUSH_ON_FULL_POP (0)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wr_en),
    .wdata (tx_data),
    .pop   (tx_pop),
    .rdata (tx_head),
    .empty (tx_empty),
    .full  (tx_full),
    .count ()
  );

  tx_state_t         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_line_d, tx_bit_end;

  // TX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state_q <= TX_IDLE;
    else      tx_state_q <= tx_state_d;
  end

  // TX next state, FIFO pop and next line level
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    tx_bit_end = (tx_cnt_q == CNT_FULL);
    if (tx_bit_end) tx_cnt_d = '0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          tx_par_d   = (^tx_head) ^ PAR_ODD;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_bit_q == BIT_LAST) tx_state_d = PAR_ON ? TX_PARITY : TX_STOP;
          else                      tx_bit_d   = tx_bit_q + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) tx_state_d = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_par_d   = (^tx_head) ^ PAR_ODD;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_sh_d[0];
      TX_PARITY: tx_line_d = tx_par_d;
      default:   tx_line_d = 1'b1;
    endcase
  end

  // TX datapath and registered line/busy outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_par_q <= tx_par_d;
      tx       <= tx_line_d;
      tx_busy  <= (tx_state_d != TX_IDLE);
    end
  end

  // ---------------------------------------------------------------- RX path
  logic rx_meta, rx_sync, rx_prev;

  // Two-flop synchroniser plus previous value for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_t         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              rx_par_q, rx_par_d;
  logic              rx_sample, rx_par_bad;
  logic              fe_d, pe_d, push_d, push_q;

  // RX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state_q <= RX_IDLE;
    else      rx_state_q <= rx_state_d;
  end

  // RX next state, bit sampling and frame verdict at the stop sample
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    fe_d       = 1'b0;
    pe_d       = 1'b0;
    push_d     = 1'b0;
    rx_sample  = (rx_cnt_q == ((rx_state_q == RX_START) ? CNT_HALF : CNT_FULL));
    rx_par_bad = PAR_ON && (rx_par_q != ((^rx_sh_q) ^ PAR_ODD));
    if (rx_sample) rx_cnt_d = '0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev && !rx_sync) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_sample) begin
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_sh_d = {rx_sync, rx_sh_q[DATA_W-1:1]};
          if (rx_bit_q == BIT_LAST) rx_state_d = PAR_ON ? RX_PARITY : RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_par_d   = rx_sync;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          fe_d       = ~rx_sync;
          pe_d       = rx_par_bad;
          push_d     = rx_sync & ~rx_par_bad;
          rx_state_d = rx_sync ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        rx_cnt_d = '0;
        if (rx_sync) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX datapath, push strobe and error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      push_q     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      push_q     <= push_d;
      frame_err  <= fe_d;
      parity_err <= pe_d;
      overrun    <= push_q & rx_full & ~(rx_rd_en & ~rx_empty);
    end
  end

  uart_fifo_link_fifo #(
    .W                (DATA_W),
    .DEPTH            (FIFO_DEPTH),
    .PUSH_ON_FULL_POP (1)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (rx_sh_q),
    .pop   (rx_rd_en),
    .rdata (rx_data),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );
endmodule

// File: tb/tb_uart_fifo_link.sv
// tb/tb_uart_fifo_link.sv - directed self-checking bench for uart_fifo_link
module tb_uart_fifo_link;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       loop = 1'b0;
  logic       line0 = 1'b1, line1 = 1'b1;
  logic       rx0;
  logic       tx0, tx1;
  logic       rx_rd_en0 = 1'b0, rx_rd_en1 = 1'b0;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_empty0, rx_empty1, rx_full0, rx_full1;
  logic [2:0] rx_count0, rx_count1;
  logic       tx_wr_en0 = 1'b0, tx_wr_en1 = 1'b0;
  logic [7:0] tx_data0 = 8'h00, tx_data1 = 8'h00;
  logic       tx_full0, tx_full1, tx_empty0, tx_empty1, tx_busy0, tx_busy1;
  logic       fe0, fe1, pe0, pe1, ov0, ov1;

  assign rx0 = loop ? tx0 : line0;

  uart_fifo_link #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .tx(tx0),
    .rx_rd_en(rx_rd_en0), .rx_data(rx_data0), .rx_empty(rx_empty0),
    .rx_full(rx_full0), .rx_count(rx_count0),
    .tx_wr_en(tx_wr_en0), .tx_data(tx_data0), .tx_full(tx_full0),
    .tx_empty(tx_empty0), .tx_busy(tx_busy0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
  );

  uart_fifo_link #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut1 (
    .clk(clk), .rst(rst), .rx(line1), .tx(tx1),
    .rx_rd_en(rx_rd_en1), .rx_data(rx_data1), .rx_empty(rx_empty1),
    .rx_full(rx_full1), .rx_count(rx_count1),
    .tx_wr_en(tx_wr_en1), .tx_data(tx_data1), .tx_full(tx_full1),
    .tx_empty(tx_empty1), .tx_busy(tx_busy1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
  );

  int checks = 0;
  int failures = 0;

  // Pulse counters and line activity monitors, sampled mid-cycle
  int fe0_n = 0, pe0_n = 0, ov0_n = 0, fe1_n = 0, pe1_n = 0;
  int busy_cycles = 0, busy_starts = 0, tx_low = 0, peak0 = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (fe0) fe0_n++;
    if (pe0) pe0_n++;
    if (ov0) ov0_n++;
    if (fe1) fe1_n++;
    if (pe1) pe1_n++;
    if (tx_busy0) busy_cycles++;
    if (tx_busy0 && !busy_prev) busy_starts++;
    busy_prev = tx_busy0;
    if (!tx0) tx_low++;
    if (int'(rx_count0) > peak0) peak0 = int'(rx_count0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic v, input int nbits);
    if (which == 0) line0 = v;
    else            line1 = v;
    repeat (nbits * CPB) @(posedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input bit use_par,
                            input bit par, input bit stop, input int stop_bits);
    drive(which, 1'b0, 1);
    for (int i = 0; i < 8; i++) drive(which, d[i], 1);
    if (use_par) drive(which, par, 1);
    drive(which, stop, stop_bits);
    drive(which, 1'b1, 2);
    @(negedge clk);
  endtask

  task automatic pop0(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, rx_data0, exp);
    rx_rd_en0 = 1'b1;
    @(negedge clk);
    rx_rd_en0 = 1'b0;
  endtask

  int busy_base, starts_base, low_base;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx0, 1);
    check("rst_tx_busy", tx_busy0, 0);
    check("rst_rx_empty", rx_empty0, 1);
    check("rst_tx_empty", tx_empty0, 1);
    check("rst_rx_full", rx_full0, 0);
    check("rst_tx_full", tx_full0, 0);
    check("rst_rx_count", rx_count0, 0);
    check("rst_rx_data", rx_data0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // glitch: 4 low cycles must not start a frame
    line0 = 1'b0;
    repeat (4) @(negedge clk);
    line0 = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_rx_empty", rx_empty0, 1);
    check("glitch_fe", fe0_n, 0);
    check("glitch_pe", pe0_n, 0);

    // loopback of three back-to-back bytes
    loop = 1'b1;
    busy_base = busy_cycles;
    starts_base = busy_starts;
    @(negedge clk);
    tx_wr_en0 = 1'b1; tx_data0 = 8'hA5;
    @(negedge clk);
    check("lat_tx_empty_fall", tx_empty0, 0);
    check("lat_tx_idle_still", tx0, 1);
    tx_data0 = 8'h3C;
    @(negedge clk);
    check("lat_tx_start", tx0, 0);
    check("lat_tx_busy", tx_busy0, 1);
    tx_data0 = 8'hFF;
    @(negedge clk);
    tx_wr_en0 = 1'b0;
    repeat (520) @(negedge clk);
    check("loop_busy_cycles", busy_cycles - busy_base, 480);
    check("loop_busy_starts", busy_starts - starts_base, 1);
    check("loop_rx_count", rx_count0, 3);
    check("loop_peak", peak0, 3);
    pop0("loop_b0", 8'hA5);
    pop0("loop_b1", 8'h3C);
    pop0("loop_b2", 8'hFF);
    check("loop_rx_empty", rx_empty0, 1);
    check("loop_fe", fe0_n, 0);
    loop = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // framing error with stop held low for three bit times
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0, 3);
    check("frame_fe", fe0_n, 1);
    check("frame_rx_count", rx_count0, 0);
    send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1, 1);
    check("frame_next_count", rx_count0, 1);
    check("frame_fe_once", fe0_n, 1);
    pop0("frame_next_data", 8'h42);

    // overrun: five frames into a four-deep FIFO
    for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, 1);
    check("ovr_full", rx_full0, 1);
    check("ovr_count4", rx_count0, 4);
    check("ovr_none_yet", ov0_n, 0);
    send_frame(0, 8'h05, 1'b0, 1'b0, 1'b1, 1);
    check("ovr_pulse", ov0_n, 1);
    check("ovr_count_kept", rx_count0, 4);
    pop0("ovr_b1", 8'h01);
    pop0("ovr_b2", 8'h02);
    pop0("ovr_b3", 8'h03);
    pop0("ovr_b4", 8'h04);
    check("ovr_empty", rx_empty0, 1);

    // even parity on the second instance
    send_frame(1, 8'h55, 1'b1, 1'b1, 1'b1, 1);
    check("par_bad_pulse", pe1_n, 1);
    check("par_bad_count", rx_count1, 0);
    check("par_bad_no_fe", fe1_n, 0);
    send_frame(1, 8'h55, 1'b1, 1'b0, 1'b1, 1);
    check("par_ok_count", rx_count1, 1);
    check("par_ok_data", rx_data1, 8'h55);
    check("par_ok_pe", pe1_n, 1);

    // reset in the middle of a transmitted frame
    @(negedge clk);
    tx_wr_en0 = 1'b1; tx_data0 = 8'hA5;
    @(negedge clk);
    tx_wr_en0 = 1'b0;
    repeat (70) @(negedge clk);
    check("mid_busy_before", tx_busy0, 1);
    check("mid_bit3_low", tx0, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_tx", tx0, 1);
    check("mid_rst_busy", tx_busy0, 0);
    check("mid_rst_tx_empty", tx_empty0, 1);
    repeat (3) @(negedge clk);
    check("mid_rst_tx_hold", tx0, 1);
    check("mid_rst_rx1_flushed", rx_count1, 0);
    rst = 1'b1;
    low_base = tx_low;
    repeat (200) @(negedge clk);
    check("mid_no_residual", tx_low - low_base, 0);
    check("mid_idle_busy", tx_busy0, 0);
    check("mid_idle_tx_empty", tx_empty0, 1);
    check("mid_no_fe", fe0_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_fifo_link.md
# uart_fifo_link

Parametrised full-duplex UART with buffered receive and transmit paths. It succeeds the fixed 8-bit RX→FIFO block. This generation adds configurable data width, baud divisor, FIFO depth and optional parity, plus a transmit FIFO, error reporting and overrun handling. It sits between the serial pins and a host-side push/pop interface.

## Interface
- DATA_W, 8: data bits per frame, legal range 5–8.
- CLKS_PER_BIT, 868: clk cycles per serial bit, minimum 8.
- FIFO_DEPTH, 16: entries in each FIFO; power of two, minimum 2.
- PARITY_EN, 0: 1 inserts and checks a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity.

- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, asynchronous to clk.
- tx  out  1  serial output, idles high.
- rx_rd_en  in  1  pops the RX FIFO head.
- rx_data  out  DATA_W  RX FIFO head (first-word-fall-through).
- rx_empty  out  1  RX FIFO holds no entries.
- rx_full  out  1  RX FIFO holds FIFO_DEPTH entries.
- rx_count  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
- tx_wr_en  in  1  pushes tx_data into the TX FIFO.
- tx_data  in  DATA_W  byte to transmit.
- tx_full  out  1  TX FIFO full.
- tx_empty  out  1  TX FIFO empty.
- tx_busy  out  1  a frame is on the line.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overrun  out  1  one-cycle pulse: valid frame dropped because the RX FIFO was full.

## Operation
- Frame format: start bit (0), then DATA_W data bits LSB first, then a parity bit if PARITY_EN, then one stop bit (1).
- Parity bit: XOR of the data bits for even parity. For odd parity it is the inverse of that XOR.
- Reset values: tx=1, tx_busy=0, rx_empty=1, tx_empty=1, rx_full=0, tx_full=0, rx_count=0, all error pulses 0. rx_data is forced to 0 whenever rx_empty=1.
- RX synchronisation: rx passes through a 2-flop synchroniser, which resets to 1.
- RX FSM states: IDLE → START → DATA → PARITY (skipped if PARITY_EN=0) → STOP → IDLE.
- IDLE → START on a synchronised falling edge of rx.
- START: at CLKS_PER_BIT/2 cycles, rx is resampled. If it is high, the start is treated as a glitch and the FSM returns to IDLE. If it is low, the FSM moves to DATA.
- DATA, PARITY and STOP: each bit is sampled CLKS_PER_BIT cycles after the previous sample point.
- STOP sample = 0: frame_err pulses and the byte is discarded. The FSM then waits for rx=1 before it re-enters IDLE (break handling).
- Parity mismatch: parity_err pulses at the stop sample and the byte is discarded. If the stop bit is also 0, both pulses fire in the same cycle.
- Valid frame: written to the RX FIFO in the cycle after the stop sample. If the FIFO is full and no pop occurs in that cycle, overrun pulses, the byte is dropped and FIFO contents are unchanged.
- RX FIFO:
  - Pointers carry one extra wrap bit; full when the indices match and the wrap bits differ.
  - Push and pop in the same cycle are both performed, including when full; count is unchanged.
  - rx_rd_en while empty is ignored.
- TX FIFO:
  - tx_wr_en while tx_full is ignored.
  - Push and pop in the same cycle are allowed.
- TX FSM states: IDLE → START → DATA → PARITY (optional) → STOP → IDLE.
  - In IDLE with the TX FIFO not empty, the FSM pops the head and enters START.
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - At the end of STOP, if the FIFO is not empty, the FSM goes directly to START with no idle gap. Otherwise it goes to IDLE.
- tx_busy is 1 in START, DATA, PARITY and STOP.
- Reset assertion at any time, including mid-frame: tx returns to 1 immediately and both FIFOs are emptied. Any partial RX frame is discarded, with no error pulse.

## Timing
- TX latency: tx_wr_en at edge E0 into an empty FIFO with the FSM idle. tx_empty falls after E0. The FSM pops at E1, so tx=0 and tx_busy=1 after E1.
- Frame length: (2 + DATA_W + PARITY_EN) × CLKS_PER_BIT cycles.
- RX latency: rx_empty falls 2 cycles after the stop-bit sample point (one cycle for the FIFO write, one for the flag update), with rx_data valid in the same cycle.
- Pop: rx_rd_en at edge E advances the head. The next entry, or rx_empty=1, is visible after E.
- All outputs are registered, except rx_data, which is a combinational read of the FIFO memory at the head pointer, gated by rx_empty.

## Test plan
- Reset mid-frame (CLKS_PER_BIT=16): start a TX of 0xA5, then assert rst at bit 3 → tx=1, tx_busy=0, tx_empty=1 while rst is low; no residual frame after release.
- Loopback tx→rx (DATA_W=8, no parity): push 0xA5, 0x3C, 0xFF back-to-back → tx_busy stays high for 480 cycles with no gap; RX FIFO returns 0xA5, 0x3C, 0xFF in order; rx_count peaks at 3.
- Parity (PARITY_EN=1, even): drive 0x55 with parity bit 1 → parity_err pulses once and rx_count stays 0. Then drive 0x55 with parity 0 → entry 0x55 is stored.
- Framing: drive 0x81 with stop bit 0 held low for 3 bit times → frame_err pulses once; no reception occurs until rx returns high; a following 0x42 is received correctly.
- Overrun (FIFO_DEPTH=4): drive 5 frames 0x01–0x05 with no pops → rx_full=1 after the 4th frame; overrun pulses on the 5th; pops return 0x01–0x04.
- Glitch: rx low for 4 cycles (CLKS_PER_BIT=16) → no frame, no error pulse, rx_empty stays 1.
